psum_row_accum: RTL and testbench

//  Parametrised row partial-sum accumulator; successor to the fixed psum buffer in the EPU datapath.

---
 rtl/epu_psum_pkg.sv | 24 ++
 rtl/psum_requant.sv | 40 ++++
 rtl/psum_row_accum.sv | 169 ++++++++++++++++
 tb/tb_psum_row_accum.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/epu_psum_pkg.sv
// Shared types and helpers for the row partial-sum accumulator: FSM states, accumulator width, saturation bounds.
// Pure declarations; no timing or flow control of its own.
package epu_psum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // One guard bit per doubling of the channel count keeps the channel sum from overflowing.
  function automatic int acc_w(input int psum_w, input int ch_w);
    return psum_w + ch_w;
  endfunction

  function automatic logic signed [31:0] sat_max(input int out_w);
    return (32'sd1 <<< (out_w - 1)) - 32'sd1;
  endfunction

  function automatic logic signed [31:0] sat_min(input int out_w);
    return -(32'sd1 <<< (out_w - 1));
  endfunction

endpackage

// File: rtl/psum_requant.sv
// Requantizer: round-half-up, arithmetic shift, optional ReLU, saturate ACC_W -> OUT_W.
// Purely combinational, zero latency; no flow control.
module psum_requant
  import epu_psum_pkg::*;
#(
  parameter int ACC_W   = 29,
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 5
) (
  input  logic signed [ACC_W-1:0]   acc,
  input  logic        [SHIFT_W-1:0] shift,
  input  logic                      relu_en,
  output logic signed [OUT_W-1:0]   pix
);

  // Wide enough that the rounding constant for the largest shift cannot overflow the sum.
  localparam int RW = ACC_W + (1 << SHIFT_W) + 1;
  localparam logic signed [RW-1:0] MAX_V = RW'(sat_max(OUT_W));
  localparam logic signed [RW-1:0] MIN_V = RW'(sat_min(OUT_W));

  logic signed [RW-1:0] ext;
  logic signed [RW-1:0] rnd;
  logic signed [RW-1:0] sum;
  logic signed [RW-1:0] shr;
  logic signed [RW-1:0] clip;

  always_comb begin
    ext = RW'(acc);
    rnd = '0;
    if (shift != '0) rnd = RW'(1) << (shift - SHIFT_W'(1));
    sum = ext + rnd;
    shr = sum >>> shift;
    if (relu_en && shr[RW-1]) shr = '0;
    if (shr > MAX_V)      clip = MAX_V;
    else if (shr < MIN_V) clip = MIN_V;
    else                  clip = shr;
    pix = OUT_W'(clip);
  end

endmodule

// File: rtl/psum_row_accum.sv
// Row psum accumulator over N channels, then requant + drain; output registered, first pixel 1 cycle after DRAIN entry.
// Drain stalls on i_out_ready low with data held; optional 2:1 max pool under PSUM_MAXPOOL2_EN.
module psum_row_accum
  import epu_psum_pkg::*;
#(
  parameter int PSUM_W  = 24,
  parameter int OUT_W   = 8,
  parameter int ROW_MAX = 64,
  parameter int CH_W    = 5,
  parameter int SHIFT_W = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_row_start,
  input  logic [$clog2(ROW_MAX+1)-1:0]     i_row_len,
  input  logic [CH_W-1:0]                  i_ch_num,
  input  logic [SHIFT_W-1:0]               i_shift,
  input  logic                             i_relu_en,
  input  logic                             i_pool_en,
  input  logic                             i_psum_valid,
  input  logic signed [PSUM_W-1:0]         i_psum,
  output logic                             o_psum_ready,
  output logic                             o_out_valid,
  output logic signed [OUT_W-1:0]          o_out_data,
  input  logic                             i_out_ready,
  output logic                             o_busy,
  output logic                             o_row_done,
  output logic                             o_err_busy
);

  localparam int ACC_W = acc_w(PSUM_W, CH_W);
  localparam int LEN_W = $clog2(ROW_MAX + 1);
  localparam int IDX_W = (ROW_MAX > 1) ? $clog2(ROW_MAX) : 1;

  state_t state, state_nxt;

  logic [LEN_W-1:0]        pix, len_q, len_in, step, rd_nxt, rd_idx;
  logic [CH_W-1:0]         ch, ch_num_q;
  logic [SHIFT_W-1:0]      shift_q;
  logic                    relu_q;
  logic signed [ACC_W-1:0] acc [ROW_MAX];
  logic                    psum_fire, last_pix, last_ch, rd_fire, rd_last;
  logic signed [OUT_W-1:0] rq_a, pix_out;

  assign len_in    = (i_row_len > LEN_W'(ROW_MAX)) ? LEN_W'(ROW_MAX) : i_row_len;
  assign psum_fire = (state == ACCUM) && i_psum_valid;
  assign last_pix  = (pix == len_q - 1'b1);
  assign last_ch   = (ch == ch_num_q);
  assign rd_fire   = (state == DRAIN) && o_out_valid && i_out_ready;
  assign rd_nxt    = pix + step;
  assign rd_last   = (rd_nxt >= len_q);
  // Look ahead to the next pixel on a handshake so o_out_valid never drops between pixels.
  assign rd_idx    = rd_fire ? rd_nxt : pix;

  assign o_busy       = (state != IDLE);
  assign o_psum_ready = (state == ACCUM);

  psum_requant #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)) u_rq_a (
    .acc     (acc[rd_idx[IDX_W-1:0]]),
    .shift   (shift_q),
    .relu_en (relu_q),
    .pix     (rq_a)
  );

`ifdef PSUM_MAXPOOL2_EN
  logic                    pool_q;
  logic [LEN_W-1:0]        rd_idx_b;
  logic signed [OUT_W-1:0] rq_b;
  logic                    has_pair;

  assign step     = pool_q ? LEN_W'(2) : LEN_W'(1);
  assign rd_idx_b = rd_idx + 1'b1;
  // An odd-length row ends with a lone pixel that is passed through unpaired.
  assign has_pair = pool_q && (rd_idx_b < len_q);
  assign pix_out  = (has_pair && (rq_b > rq_a)) ? rq_b : rq_a;

  psum_requant #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)) u_rq_b (
    .acc     (acc[rd_idx_b[IDX_W-1:0]]),
    .shift   (shift_q),
    .relu_en (relu_q),
    .pix     (rq_b)
  );
`else
  logic unused_pool;
  assign unused_pool = i_pool_en;
  assign step        = LEN_W'(1);
  assign pix_out     = rq_a;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_row_start && (len_in != '0)) state_nxt = ACCUM;
      ACCUM:   if (psum_fire && last_pix && last_ch) state_nxt = DRAIN;
      DRAIN:   if (rd_fire && rd_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix         <= '0;
      ch          <= '0;
      len_q       <= '0;
      ch_num_q    <= '0;
      shift_q     <= '0;
      relu_q      <= 1'b0;
`ifdef PSUM_MAXPOOL2_EN
      pool_q      <= 1'b0;
`endif
      o_out_valid <= 1'b0;
      o_out_data  <= '0;
      o_row_done  <= 1'b0;
      o_err_busy  <= 1'b0;
    end else begin
      o_row_done <= 1'b0;
      o_err_busy <= 1'b0;
      if (i_row_start) begin
        if (state != IDLE) begin
          o_err_busy <= 1'b1;
        end else begin
          len_q    <= len_in;
          ch_num_q <= i_ch_num;
          shift_q  <= i_shift;
          relu_q   <= i_relu_en;
`ifdef PSUM_MAXPOOL2_EN
          pool_q   <= i_pool_en;
`endif
          pix      <= '0;
          ch       <= '0;
          if (len_in == '0) o_row_done <= 1'b1;
        end
      end
      if (psum_fire) begin
        if (last_pix) begin
          pix <= '0;
          ch  <= last_ch ? '0 : ch + 1'b1;
        end else begin
          pix <= pix + 1'b1;
        end
      end
      if (state == DRAIN) begin
        if (rd_fire && rd_last) begin
          o_out_valid <= 1'b0;
          pix         <= '0;
          o_row_done  <= 1'b1;
        end else if (!o_out_valid || rd_fire) begin
          o_out_valid <= 1'b1;
          o_out_data  <= pix_out;
          pix         <= rd_idx;
        end
      end
    end
  end

  // Channel 0 overwrites, so stale contents from a previous or aborted row never leak in.
  always_ff @(posedge clk) begin
    if (psum_fire) begin
      if (ch == '0) acc[pix[IDX_W-1:0]] <= ACC_W'(i_psum);
      else          acc[pix[IDX_W-1:0]] <= acc[pix[IDX_W-1:0]] + ACC_W'(i_psum);
    end
  end

endmodule

// File: tb/tb_psum_row_accum.sv
// Scoreboard bench for psum_row_accum: directed rows push expected pixels, a negedge monitor pops and compares.
module tb_psum_row_accum;

  localparam int PSUM_W  = 24;
  localparam int OUT_W   = 8;
  localparam int ROW_MAX = 64;
  localparam int CH_W    = 5;
  localparam int SHIFT_W = 5;
  localparam int LEN_W   = $clog2(ROW_MAX + 1);

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic                      i_row_start = 1'b0;
  logic [LEN_W-1:0]          i_row_len = '0;
  logic [CH_W-1:0]           i_ch_num = '0;
  logic [SHIFT_W-1:0]        i_shift = '0;
  logic                      i_relu_en = 1'b0;
  logic                      i_pool_en = 1'b0;
  logic                      i_psum_valid = 1'b0;
  logic signed [PSUM_W-1:0]  i_psum = '0;
  logic                      o_psum_ready;
  logic                      o_out_valid;
  logic signed [OUT_W-1:0]   o_out_data;
  logic                      i_out_ready = 1'b1;
  logic                      o_busy;
  logic                      o_row_done;
  logic                      o_err_busy;

  psum_row_accum #(
    .PSUM_W(PSUM_W), .OUT_W(OUT_W), .ROW_MAX(ROW_MAX), .CH_W(CH_W), .SHIFT_W(SHIFT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_row_start  (i_row_start),
    .i_row_len    (i_row_len),
    .i_ch_num     (i_ch_num),
    .i_shift      (i_shift),
    .i_relu_en    (i_relu_en),
    .i_pool_en    (i_pool_en),
    .i_psum_valid (i_psum_valid),
    .i_psum       (i_psum),
    .o_psum_ready (o_psum_ready),
    .o_out_valid  (o_out_valid),
    .o_out_data   (o_out_data),
    .i_out_ready  (i_out_ready),
    .o_busy       (o_busy),
    .o_row_done   (o_row_done),
    .o_err_busy   (o_err_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_hs = 0;
  bit chk_done_timing = 1'b0;
  bit rdy_toggle = 1'b0;
  bit prev_stall = 1'b0;
  logic signed [OUT_W-1:0] prev_data;
  logic signed [OUT_W-1:0] mon_e;
  logic signed [OUT_W-1:0] exp_q[$];
  int stim[$];
  int expv[$];

  always @(posedge clk) cyc++;

  // Downstream readiness: steady 1, or a 1,0,1,0 pattern for backpressure rows.
  always @(posedge clk) begin
    #1;
    if (rdy_toggle) i_out_ready = ~i_out_ready;
    else            i_out_ready = 1'b1;
  end

  always @(negedge clk) begin
    if (rst) begin
      if (prev_stall) begin
        checks++;
        if (!o_out_valid || (o_out_data !== prev_data)) begin
          failures++;
          $display("FAIL stall_hold got valid=%0b data=%0d exp valid=1 data=%0d", o_out_valid, o_out_data, prev_data);
        end
      end
      if (o_out_valid && i_out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL out_unexpected got=%0d exp=none", o_out_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (o_out_data !== mon_e) begin
            failures++;
            $display("FAIL out_data got=%0d exp=%0d", o_out_data, mon_e);
          end
        end
        last_hs = cyc;
      end
      prev_stall = o_out_valid && !i_out_ready;
      prev_data  = o_out_data;
      if (o_row_done) begin
        done_cnt++;
        if (chk_done_timing) begin
          checks++;
          if (cyc != last_hs + 1) begin
            failures++;
            $display("FAIL done_timing got=cycle %0d exp=cycle %0d", cyc, last_hs + 1);
          end
        end
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic start_row(input int len, input int chn, input int sh, input bit relu, input bit pool);
    i_row_start = 1'b1;
    i_row_len   = LEN_W'(len);
    i_ch_num    = CH_W'(chn);
    i_shift     = SHIFT_W'(sh);
    i_relu_en   = relu;
    i_pool_en   = pool;
    tick;
    i_row_start = 1'b0;
  endtask

  task automatic send(input int v);
    int n = 0;
    while (!o_psum_ready && n < 100) begin
      tick;
      n++;
    end
    if (!o_psum_ready) begin
      checks++;
      failures++;
      $display("FAIL psum_ready_timeout got=0 exp=1");
    end
    i_psum_valid = 1'b1;
    i_psum       = PSUM_W'(v);
    tick;
    i_psum_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < 1000) begin
      tick;
      n++;
    end
    chk({name, "_done"}, done_cnt - d0, 1);
  endtask

  task automatic run_row(input string name, input int len, input int chn, input int sh,
                         input bit relu, input bit pool);
    foreach (expv[i]) exp_q.push_back(OUT_W'(expv[i]));
    start_row(len, chn, sh, relu, pool);
    foreach (stim[i]) send(stim[i]);
    wait_done(name);
    stim.delete();
    expv.delete();
  endtask

  initial begin
    repeat (3) tick;
    chk("rst_busy", o_busy, 0);
    chk("rst_psum_ready", o_psum_ready, 0);
    chk("rst_out_valid", o_out_valid, 0);
    chk("rst_out_data", o_out_data, 0);
    chk("rst_row_done", o_row_done, 0);
    chk("rst_err_busy", o_err_busy, 0);
    rst = 1'b1;
    tick;
    chk_done_timing = 1'b1;

    stim = '{1, 2, 3, 4};
    expv = '{1, 2, 3, 4};
    run_row("t1", 4, 0, 0, 1'b0, 1'b0);

    stim = '{10, 10, 10, 10, 10, 10, 10, 10, 10};
    expv = '{8, 8, 8};
    run_row("t2", 3, 2, 2, 1'b0, 1'b0);

    stim = '{1000, -1000};
    expv = '{127, -128};
    run_row("t3_sat", 2, 0, 0, 1'b0, 1'b0);
    stim = '{1000, -1000};
    expv = '{127, 0};
    run_row("t3_relu", 2, 0, 0, 1'b1, 1'b0);

    // acc = 6,-5,97,300; shift 1 rounds to 3,-2,49,150 -> 150 saturates to 127.
    rdy_toggle = 1'b1;
    stim = '{5, -6, 100, 200, 1, 1, -3, 100};
    expv = '{3, -2, 49, 127};
    run_row("t4", 4, 1, 1, 1'b0, 1'b0);
    rdy_toggle = 1'b0;
    tick;

    exp_q.push_back(OUT_W'(50));
    exp_q.push_back(OUT_W'(-7));
    start_row(2, 0, 0, 1'b0, 1'b0);
    send(50);
    i_row_start = 1'b1;
    i_row_len   = LEN_W'(1);
    tick;
    i_row_start = 1'b0;
    chk("t5_err_busy", o_err_busy, 1);
    chk("t5_still_busy", o_busy, 1);
    tick;
    chk("t5_err_pulse_end", o_err_busy, 0);
    send(-7);
    wait_done("t5");

    chk_done_timing = 1'b0;
    start_row(0, 0, 0, 1'b0, 1'b0);
    chk("len0_done", o_row_done, 1);
    chk("len0_idle", o_busy, 0);
    tick;
    chk("len0_done_pulse_end", o_row_done, 0);
    chk_done_timing = 1'b1;

    for (int i = 0; i < ROW_MAX; i++) begin
      stim.push_back(i);
      expv.push_back(i);
    end
    run_row("clamp", 100, 0, 0, 1'b0, 1'b0);

    stim = '{3, 7, -2, -5, 9};
`ifdef PSUM_MAXPOOL2_EN
    expv = '{7, -2, 9};
`else
    expv = '{3, 7, -2, -5, 9};
`endif
    run_row("t6", 5, 0, 0, 1'b0, 1'b1);

    chk_done_timing = 1'b0;
    start_row(4, 0, 0, 1'b0, 1'b0);
    send(1);
    send(2);
    #2 rst = 1'b0;
    #1;
    chk("arst_idle", o_busy, 0);
    chk("arst_psum_ready", o_psum_ready, 0);
    chk("arst_out_valid", o_out_valid, 0);
    tick;
    rst = 1'b1;
    tick;
    chk_done_timing = 1'b1;

    stim = '{4, -4};
    expv = '{4, -4};
    run_row("post_rst", 2, 0, 0, 1'b0, 1'b0);

    repeat (3) tick;
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
